// File: rtl/alu_accel_param.sv
// Bus-slave ALU accelerator: host fills operand registers and an instruction FIFO, pulses START,
// and the engine executes each instruction into a result FIFO, flagging done when the queue drains.
module alu_accel_param #(
    parameter int DATA_W     = 32,
    parameter int NREG       = 16,
    parameter int INST_DEPTH = 8,
    parameter int RES_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [15:0]       s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              s_interrupt
);
    localparam int IAW = $clog2(INST_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int SHW = $clog2(DATA_W);
    localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0] A_INST = 8'h20, A_RES = 8'h21, A_CTRL = 8'h22, A_STAT = 8'h23, A_ICLR = 8'h24;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WRITE, S_DONE} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] opr      [NREG];
    logic [19:0]       inst_mem [INST_DEPTH];
    logic [DATA_W-1:0] res_mem  [RES_DEPTH];
    logic [IAW-1:0]    inst_rd, inst_wr;
    logic [IAW:0]      inst_cnt;
    logic [RAW-1:0]    res_rd, res_wr;
    logic [RAW:0]      res_cnt;
    logic [19:0]       inst_p0;
    logic [DATA_W-1:0] result_p1;
    logic              ie, done, inst_ovf, res_unf, bad_op;

    logic        page0, host_wr, host_rd, ctrl_wr, start, soft_clr, int_clr;
    logic        inst_req, res_req, opr_hit, busy;
    logic        inst_full, inst_empty, res_full, res_empty;
    logic        inst_push, inst_pop, res_push, res_pop;
    logic [7:0]  idx;
    logic [31:0] din32;
    logic        din_unused;
    logic [20:0] stat;
    logic [DATA_W-1:0] rd_data;

    function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa, sb;
        logic [SHW-1:0]           sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[SHW-1:0];
        case (op)
            4'd0:    alu = a;
            4'd1:    alu = a + b;
            4'd2:    alu = a - b;
            4'd3:    alu = a & b;
            4'd4:    alu = a | b;
            4'd5:    alu = a ^ b;
            4'd6:    alu = ~a;
            4'd7:    alu = a << sh;
            4'd8:    alu = a >> sh;
            4'd9:    alu = sa >>> sh;
            4'd10:   alu = a * b;
            4'd11:   alu = {{(DATA_W-1){1'b0}}, (sa < sb)};
            default: alu = '0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] fetch_opr(input logic [7:0] i);
        return (int'(i) < NREG) ? opr[i[RIW-1:0]] : '0;
    endfunction

    assign page0    = s_sel && (s_addr[15:8] == 8'h00);
    assign idx      = s_addr[7:0];
    assign host_wr  = page0 && s_wr;
    assign host_rd  = page0 && !s_wr;
    assign ctrl_wr  = host_wr && (idx == A_CTRL);
    assign start    = ctrl_wr && s_din[0];
    assign soft_clr = ctrl_wr && s_din[2];
    assign int_clr  = host_wr && (idx == A_ICLR) && s_din[0];
    assign inst_req = host_wr && (idx == A_INST);
    assign res_req  = host_rd && (idx == A_RES);
    assign opr_hit  = (int'(idx) < NREG) && ((idx < A_INST) || (idx > A_ICLR));

    // Only opcode and the two operand indices of an instruction word are kept
    assign din32      = 32'(s_din);
    assign din_unused = ^{din32[31:28], din32[23:16]};

    assign inst_full  = (inst_cnt == (IAW+1)'(INST_DEPTH));
    assign inst_empty = (inst_cnt == '0);
    assign res_full   = (res_cnt == (RAW+1)'(RES_DEPTH));
    assign res_empty  = (res_cnt == '0);

    // Simultaneous push and pop on a full FIFO both succeed
    assign res_pop   = res_req && !res_empty;
    assign inst_push = inst_req && (!inst_full || inst_pop);

    always_ff @(posedge clk) begin
        if (!reset_n || soft_clr) state <= S_IDLE;
        else                      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: state_next = inst_empty ? S_DONE : S_EXEC;
            S_EXEC:  state_next = S_WRITE;
            S_WRITE: if (!res_full || res_pop) state_next = S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        inst_pop = (state == S_FETCH) && !inst_empty && !soft_clr;
        res_push = (state == S_WRITE) && (!res_full || res_pop) && !soft_clr;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) opr[i] <= '0;
        end else if (opr_hit && host_wr) begin
            opr[idx[RIW-1:0]] <= s_din;
        end
    end

    always_ff @(posedge clk) begin
        if (inst_push) inst_mem[inst_wr] <= {din32[27:24], din32[15:0]};
        if (res_push)  res_mem[res_wr]   <= result_p1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || soft_clr) begin
            inst_rd <= '0; inst_wr <= '0; inst_cnt <= '0;
            res_rd  <= '0; res_wr  <= '0; res_cnt  <= '0;
        end else begin
            if (inst_push) inst_wr <= inst_wr + 1'b1;
            if (inst_pop)  inst_rd <= inst_rd + 1'b1;
            if (res_push)  res_wr  <= res_wr + 1'b1;
            if (res_pop)   res_rd  <= res_rd + 1'b1;
            case ({inst_push, inst_pop})
                2'b10:   inst_cnt <= inst_cnt + 1'b1;
                2'b01:   inst_cnt <= inst_cnt - 1'b1;
                default: inst_cnt <= inst_cnt;
            endcase
            case ({res_push, res_pop})
                2'b10:   res_cnt <= res_cnt + 1'b1;
                2'b01:   res_cnt <= res_cnt - 1'b1;
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    // Stage p0: instruction popped in FETCH; stage p1: result computed in EXEC from live operands
    always_ff @(posedge clk) begin
        if (inst_pop)          inst_p0   <= inst_mem[inst_rd];
        if (state == S_EXEC)   result_p1 <= alu(inst_p0[19:16], fetch_opr(inst_p0[15:8]), fetch_opr(inst_p0[7:0]));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ie <= 1'b0; done <= 1'b0; inst_ovf <= 1'b0; res_unf <= 1'b0; bad_op <= 1'b0;
        end else if (soft_clr) begin
            done <= 1'b0; inst_ovf <= 1'b0; res_unf <= 1'b0; bad_op <= 1'b0;
        end else begin
            if (ctrl_wr)                                    ie       <= s_din[1];
            if (state == S_DONE)                            done     <= 1'b1;
            else if (int_clr)                               done     <= 1'b0;
            if (inst_req && inst_full && !inst_pop)         inst_ovf <= 1'b1;
            if (res_req && res_empty)                       res_unf  <= 1'b1;
            if ((state == S_EXEC) && (inst_p0[19:16] > 4'd11)) bad_op <= 1'b1;
        end
    end

    assign stat = {bad_op, res_unf, inst_ovf, done, busy, 8'(res_cnt), 8'(inst_cnt)};

    always_comb begin
        rd_data = '0;
        if (page0) begin
            case (idx)
                A_RES:   rd_data = res_empty ? '0 : res_mem[res_rd];
                A_CTRL:  rd_data[1] = ie;
                A_STAT:  rd_data = DATA_W'(stat);
                default: if (opr_hit) rd_data = opr[idx[RIW-1:0]];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)            s_dout <= '0;
        else if (s_sel && !s_wr) s_dout <= rd_data;
    end

    assign s_interrupt = done && ie;

endmodule

// File: tb/tb_alu_accel_param.sv
// Directed scoreboard bench for alu_accel_param at default parameters.
module tb_alu_accel_param;
    localparam logic [15:0] A_INST = 16'h20, A_RES = 16'h21, A_CTRL = 16'h22, A_STAT = 16'h23, A_ICLR = 16'h24;

    logic        clk = 1'b0, reset_n = 1'b0, s_sel = 1'b0, s_wr = 1'b0;
    logic [15:0] s_addr = '0;
    logic [31:0] s_din = '0;
    logic [31:0] s_dout;
    logic        s_interrupt;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] tbl [12];
    logic [31:0] rd, st;

    alu_accel_param #(.DATA_W(32), .NREG(16), .INST_DEPTH(8), .RES_DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_dout(s_dout), .s_interrupt(s_interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk); s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(posedge clk); #1; s_sel = 1'b0; s_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk); s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        @(posedge clk); #1; s_sel = 1'b0; d = s_dout;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return {4'h0, op, 8'h00, a, b};
    endfunction

    task automatic push_inst(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [31:0] expv, input bit sb);
        bus_wr(A_INST, mk(op, a, b));
        if (sb) exp_q.push_back(expv);
    endtask

    task automatic pop_result(input string tag);
        logic [31:0] d;
        bus_rd(A_RES, d);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed %08h expected nothing (scoreboard empty)", tag, d);
        end else begin
            check(tag, d, exp_q.pop_front());
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        logic [31:0] s;
        s = 32'h0001_0000;
        for (int k = 0; k < max && s[16]; k++) bus_rd(A_STAT, s);
        check(tag, {31'b0, s[16]}, 32'd0);
    endtask

    initial begin
        tbl = '{32'd5, 32'd8, 32'd2, 32'd1, 32'd7, 32'd6, 32'hFFFF_FFFA,
                32'd40, 32'd0, 32'd0, 32'd15, 32'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", s_dout, 32'd0);
        check("rst_irq", {31'b0, s_interrupt}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        bus_rd(A_STAT, rd); check("rst_status", rd, 32'd0);
        bus_rd(16'h0000, rd); check("rst_r0", rd, 32'd0);
        bus_rd(A_CTRL, rd); check("rst_ctrl", rd, 32'd0);

        // Basic ADD/SUB/SHL run, page decode
        bus_wr(16'h0000, 32'd5);
        bus_wr(16'h0001, 32'd3);
        bus_wr(16'h0100, 32'd77);
        bus_rd(16'h0000, rd); check("page_wr_ignored", rd, 32'd5);
        bus_rd(16'h0101, rd); check("page_rd_zero", rd, 32'd0);
        bus_rd(16'h001F, rd); check("unimpl_reg_zero", rd, 32'd0);
        push_inst(4'd1, 8'd0, 8'd1, 32'd8, 1'b1);
        push_inst(4'd2, 8'd0, 8'd1, 32'd2, 1'b1);
        push_inst(4'd7, 8'd0, 8'd1, 32'd40, 1'b1);
        bus_rd(A_STAT, rd); check("queued3", rd, 32'h0000_0003);
        bus_wr(A_CTRL, 32'h1);
        wait_idle("basic_idle", 50);
        bus_rd(A_STAT, rd); check("basic_status", rd, 32'h0002_0300);
        check("basic_irq_off", {31'b0, s_interrupt}, 32'd0);
        pop_result("res_add");
        pop_result("res_sub");
        pop_result("res_shl");

        // Interrupt with IE
        bus_wr(A_ICLR, 32'h1);
        bus_wr(A_CTRL, 32'h2);
        bus_rd(A_CTRL, rd); check("ctrl_ie", rd, 32'h2);
        push_inst(4'd5, 8'd0, 8'd1, 32'd6, 1'b1);
        bus_wr(A_CTRL, 32'h3);
        wait_idle("irq_idle", 50);
        check("irq_on", {31'b0, s_interrupt}, 32'd1);
        bus_wr(A_ICLR, 32'h1);
        check("irq_cleared", {31'b0, s_interrupt}, 32'd0);
        pop_result("res_xor");

        // Instruction FIFO overflow
        for (int i = 0; i < 8; i++) push_inst(4'd1, 8'd0, 8'd1, 32'd8, 1'b1);
        push_inst(4'd5, 8'd0, 8'd1, 32'd6, 1'b0);
        bus_rd(A_STAT, rd); check("ovf_status", rd, 32'h0004_0008);
        bus_wr(A_CTRL, 32'h3);
        wait_idle("ovf_idle", 100);
        bus_rd(A_STAT, rd); check("ovf_done_status", rd, 32'h0006_0800);
        for (int i = 0; i < 8; i++) pop_result("res_ovf");
        bus_rd(A_RES, rd); check("unf_read_zero", rd, 32'd0);
        bus_rd(A_STAT, rd); check("unf_status", rd, 32'h000E_0000);

        // Soft clear keeps operands and IE
        bus_wr(A_CTRL, 32'h6);
        bus_rd(A_STAT, rd); check("sclr_status", rd, 32'd0);
        check("sclr_irq", {31'b0, s_interrupt}, 32'd0);
        bus_rd(A_CTRL, rd); check("sclr_ie_kept", rd, 32'h2);
        bus_rd(16'h0001, rd); check("sclr_r1_kept", rd, 32'd3);

        // Result FIFO full stall with instructions fed while busy
        for (int i = 0; i < 8; i++) push_inst(4'(i % 12), 8'd0, 8'd1, tbl[i % 12], 1'b1);
        bus_wr(A_CTRL, 32'h3);
        for (int i = 8; i < 18; i++) begin
            st = 32'hFF;
            for (int k = 0; k < 40 && st[7:0] >= 8'd8; k++) bus_rd(A_STAT, st);
            push_inst(4'(i % 12), 8'd0, 8'd1, tbl[i % 12], 1'b1);
        end
        st = '0;
        for (int k = 0; k < 300 && st[15:8] != 8'd16; k++) bus_rd(A_STAT, st);
        repeat (4) bus_rd(A_STAT, st);
        check("stall_status", st, 32'h0001_1001);
        pop_result("res_stall");
        pop_result("res_stall");
        wait_idle("stall_idle", 50);
        bus_rd(A_STAT, rd); check("stall_done", rd, 32'h0002_1000);
        for (int i = 0; i < 16; i++) pop_result("res_stall");
        bus_rd(A_STAT, rd); check("stall_drained", rd, 32'h0002_0000);

        // Bad opcode
        bus_wr(A_CTRL, 32'h6);
        push_inst(4'd13, 8'd0, 8'd1, 32'd0, 1'b1);
        bus_wr(A_CTRL, 32'h3);
        wait_idle("badop_idle", 50);
        bus_rd(A_STAT, rd); check("badop_status", rd, 32'h0012_0100);
        pop_result("res_badop");

        // Soft clear mid-run
        for (int i = 0; i < 4; i++) push_inst(4'd1, 8'd0, 8'd1, 32'd8, 1'b0);
        bus_wr(A_CTRL, 32'h3);
        bus_wr(A_CTRL, 32'h6);
        bus_rd(A_STAT, rd); check("midclr_status", rd, 32'd0);
        bus_rd(A_RES, rd); check("midclr_res_empty", rd, 32'd0);

        // Sign/shift/multiply corner values and out-of-range index
        bus_wr(16'h0000, 32'h8000_0000);
        bus_wr(16'h0001, 32'h0000_0001);
        bus_wr(16'h0002, 32'h0001_0000);
        push_inst(4'd9,  8'd0,   8'd1, 32'hC000_0000, 1'b1);
        push_inst(4'd8,  8'd0,   8'd1, 32'h4000_0000, 1'b1);
        push_inst(4'd11, 8'd0,   8'd1, 32'd1, 1'b1);
        push_inst(4'd11, 8'd1,   8'd0, 32'd0, 1'b1);
        push_inst(4'd10, 8'd2,   8'd2, 32'd0, 1'b1);
        push_inst(4'd1,  8'h20,  8'd1, 32'd1, 1'b1);
        push_inst(4'd2,  8'd1,   8'd0, 32'h8000_0001, 1'b1);
        bus_wr(A_CTRL, 32'h3);
        wait_idle("corner_idle", 100);
        for (int i = 0; i < 7; i++) pop_result("res_corner");

        // Reset mid-operation
        push_inst(4'd1, 8'd0, 8'd1, 32'd0, 1'b0);
        push_inst(4'd1, 8'd0, 8'd1, 32'd0, 1'b0);
        bus_wr(A_CTRL, 32'h3);
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_dout", s_dout, 32'd0);
        check("midrst_irq", {31'b0, s_interrupt}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        bus_rd(A_STAT, rd); check("midrst_status", rd, 32'd0);
        bus_rd(16'h0000, rd); check("midrst_r0", rd, 32'd0);
        bus_rd(A_CTRL, rd); check("midrst_ctrl", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
